// File: rtl/sim_time.sv
// rtl/sim_time.sv - picosecond time base with one-at-a-time wait timer; optional tick generator under SIM_TIME_TICK_EN
module sim_time #(
    parameter int unsigned CLK_PERIOD_PS = 10000,
    parameter int          TIME_W        = 64,
    parameter int unsigned OFFSET_PS     = 0,
    parameter int unsigned TICK_PS       = 5000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wait_start_i,
    input  logic [TIME_W-1:0] wait_ps_i,
    input  logic              wait_abort_i,
    output logic [TIME_W-1:0] time_ps_o,
    output logic              wait_busy_o,
    output logic              wait_done_o,
    output logic [TIME_W-1:0] done_time_o,
    output logic              tick_o
);

    localparam logic [TIME_W-1:0] PERIOD = TIME_W'(CLK_PERIOD_PS);
    localparam logic [TIME_W-1:0] OFFSET = TIME_W'(OFFSET_PS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q;
    logic [TIME_W-1:0] time_q;
    logic [TIME_W-1:0] time_next;
    logic [TIME_W-1:0] rem_q;
    logic              done_q;
    logic [TIME_W-1:0] done_time_q;

    // Next timestamp wraps silently at 2^TIME_W.
    assign time_next = time_q + PERIOD;

    // Free-running timestamp, advanced one clock period per edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            time_q <= OFFSET;
        end else begin
            time_q <= time_next;
        end
    end

    // Wait FSM: abort beats completion, and a start in IDLE beats a concurrent abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            done_q      <= 1'b0;
            done_time_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wait_start_i) begin
                        rem_q   <= wait_ps_i;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_abort_i) begin
                        rem_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (rem_q <= PERIOD) begin
                        // Final period consumed: record the time that becomes visible with the pulse.
                        rem_q       <= '0;
                        state_q     <= ST_IDLE;
                        done_q      <= 1'b1;
                        done_time_q <= time_next;
                    end else begin
                        rem_q <= rem_q - PERIOD;
                    end
                end
                default: begin
                    rem_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign time_ps_o   = time_q;
    assign wait_busy_o = (state_q == ST_WAIT);
    assign wait_done_o = done_q;
    assign done_time_o = done_time_q;

`ifdef SIM_TIME_TICK_EN
    localparam logic [TIME_W-1:0] TICK = TIME_W'(TICK_PS);

    logic [TIME_W-1:0] acc_q;
    logic [TIME_W-1:0] acc_next;
    logic              tick_q;

    assign acc_next = acc_q + PERIOD;

    // Fractional tick accumulator: carries the remainder so ticks average TICK_PS apart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else if (acc_next >= TICK) begin
            acc_q  <= acc_next - TICK;
            tick_q <= 1'b1;
        end else begin
            acc_q  <= acc_next;
            tick_q <= 1'b0;
        end
    end

    assign tick_o = tick_q;
`else
    assign tick_o = 1'b0;
`endif

endmodule

// File: tb/tb_sim_time.sv
// tb/tb_sim_time.sv - directed self-checking bench for sim_time
module tb_sim_time;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] wait_ps;
    logic        abort;

    logic [63:0] time_ps;
    logic        busy;
    logic        done;
    logic [63:0] done_time;
    logic        tick;

    logic [63:0] time_off;
    logic        busy_off, done_off, tick_off;
    logic [63:0] done_time_off;

    logic [7:0]  time_w8;
    logic        busy_w8, done_w8, tick_w8;
    logic [7:0]  done_time_w8;
    logic [7:0]  wait_ps_w8;

    int checks;
    int failures;
    longint unsigned exp_t;
    longint unsigned t0;

    sim_time #(.CLK_PERIOD_PS(10000), .TIME_W(64), .OFFSET_PS(0), .TICK_PS(25000)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wait_start_i(start), .wait_ps_i(wait_ps),
        .wait_abort_i(abort), .time_ps_o(time_ps), .wait_busy_o(busy),
        .wait_done_o(done), .done_time_o(done_time), .tick_o(tick)
    );

    sim_time #(.CLK_PERIOD_PS(10000), .TIME_W(64), .OFFSET_PS(2500), .TICK_PS(25000)) dut_off (
        .clk_i(clk), .rst_ni(rst_n), .wait_start_i(1'b0), .wait_ps_i(64'd0),
        .wait_abort_i(1'b0), .time_ps_o(time_off), .wait_busy_o(busy_off),
        .wait_done_o(done_off), .done_time_o(done_time_off), .tick_o(tick_off)
    );

    sim_time #(.CLK_PERIOD_PS(10), .TIME_W(8), .OFFSET_PS(0), .TICK_PS(25)) dut_w8 (
        .clk_i(clk), .rst_ni(rst_n), .wait_start_i(1'b0), .wait_ps_i(wait_ps_w8),
        .wait_abort_i(1'b0), .time_ps_o(time_w8), .wait_busy_o(busy_w8),
        .wait_done_o(done_w8), .done_time_o(done_time_w8), .tick_o(tick_w8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        exp_t += 64'd10000;
    endtask

    initial begin
        checks = 0; failures = 0; exp_t = 0;
        rst_n = 1'b0; start = 1'b0; wait_ps = '0; abort = 1'b0; wait_ps_w8 = '0;
        step(); step();
        check_eq("rst_time", time_ps, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_done_time", done_time, 64'd0);
        check_eq("rst_tick", {63'd0, tick}, 64'd0);
        check_eq("rst_time_off", time_off, 64'd2500);

        rst_n = 1'b1; exp_t = 0;
        for (int i = 0; i < 10; i++) step();
        check_eq("time_10cyc", time_ps, 64'd100000);
        check_eq("time_10cyc_off", time_off, 64'd102500);
        check_eq("time_w8_100", {56'd0, time_w8}, 64'd100);
        for (int i = 0; i < 15; i++) step();
        check_eq("time_w8_250", {56'd0, time_w8}, 64'd250);
        step();
        check_eq("time_w8_wrap", {56'd0, time_w8}, 64'd4);
        check_eq("time_track", time_ps, exp_t);

        // Short waits: 5000 and 0 both take exactly one edge.
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; wait_ps = (k == 0) ? 64'd5000 : 64'd0;
            step();
            start = 1'b0;
            check_eq("short_busy", {63'd0, busy}, 64'd1);
            check_eq("short_nodone", {63'd0, done}, 64'd0);
            step();
            check_eq("short_done", {63'd0, done}, 64'd1);
            check_eq("short_busy_clr", {63'd0, busy}, 64'd0);
            check_eq("short_done_time", done_time, exp_t);
            step();
            check_eq("short_pulse_1cyc", {63'd0, done}, 64'd0);
            check_eq("short_done_time_hold", done_time, exp_t - 64'd10000);
        end

        // 25000 wait with an ignored start while busy, then a start in the done cycle.
        start = 1'b1; wait_ps = 64'd25000;
        step();
        t0 = exp_t;
        start = 1'b1; wait_ps = 64'd5000;
        check_eq("w25_busy", {63'd0, busy}, 64'd1);
        step();
        start = 1'b0;
        check_eq("w25_ignore_start", {63'd0, done}, 64'd0);
        step();
        check_eq("w25_edge2", {63'd0, done}, 64'd0);
        check_eq("w25_edge2_busy", {63'd0, busy}, 64'd1);
        step();
        check_eq("w25_done", {63'd0, done}, 64'd1);
        check_eq("w25_done_time", done_time, t0 + 64'd30000);
        start = 1'b1; wait_ps = 64'd0;
        step();
        start = 1'b0;
        check_eq("done_cyc_start_busy", {63'd0, busy}, 64'd1);
        check_eq("done_cyc_start_nodone", {63'd0, done}, 64'd0);
        step();
        check_eq("done_cyc_start_done", {63'd0, done}, 64'd1);

        // Abort after one cycle of a 50000 wait: no done pulse ever.
        start = 1'b1; wait_ps = 64'd50000;
        step();
        start = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_nodone", {63'd0, done}, 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                step();
                seen = seen | done;
            end
            check_eq("abort_no_late_done", {63'd0, seen}, 64'd0);
        end

        // Abort in the completing cycle wins over completion.
        start = 1'b1; wait_ps = 64'd10000;
        step();
        start = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_vs_done_done", {63'd0, done}, 64'd0);
        check_eq("abort_vs_done_busy", {63'd0, busy}, 64'd0);

        // Start and abort together in IDLE: start wins.
        start = 1'b1; abort = 1'b1; wait_ps = 64'd5000;
        step();
        start = 1'b0; abort = 1'b0;
        check_eq("idle_start_abort_busy", {63'd0, busy}, 64'd1);
        step();
        check_eq("idle_start_abort_done", {63'd0, done}, 64'd1);

        // Reset mid-wait: busy and done drop asynchronously.
        start = 1'b1; wait_ps = 64'd50000;
        step();
        start = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_mid_done", {63'd0, done}, 64'd0);
        check_eq("rst_mid_time", time_ps, 64'd0);
        step();
        rst_n = 1'b1; exp_t = 0;

        // Tick pattern after release: edges 3,5,8,10 with 25000 ps ticks.
        for (int i = 1; i <= 10; i++) begin
            logic exp_tick;
            step();
`ifdef SIM_TIME_TICK_EN
            exp_tick = (i == 3) || (i == 5) || (i == 8) || (i == 10);
`else
            exp_tick = 1'b0;
`endif
            check_eq($sformatf("tick_c%0d", i), {63'd0, tick}, {63'd0, exp_tick});
            check_eq($sformatf("rst_mid_no_done_c%0d", i), {63'd0, done}, 64'd0);
        end
        check_eq("time_after_rst", time_ps, 64'd100000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
